multi_adc_pulse_gen: RTL

- Parametrised successor of the two-converter average-and-pulse controller.
- Drives N_CH converters with the shared soc/eoc handshake and captures all N_CH samples together.
- Reduces the samples to one W-bit value, selected by mode: average, maximum or minimum.
- Emits a pulse on out lasting exactly that many clock periods, exposes the value on result, then starts the next conversion round.

---
 rtl/multi_adc_pulse_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multi_adc_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_adc_pulse_gen
//  Purpose  : Drives N_CH converters with a shared soc/eoc handshake, captures
//             all samples together, reduces them to one W-bit value (average,
//             maximum or minimum), then emits a pulse on out lasting exactly
//             that many clock periods before starting the next round.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock   in   1        system clock, rising edge
//    reset_  in   1        asynchronous active-low reset
//    soc     out  N_CH     start-of-conversion, all bits identical
//    eoc     in   N_CH     end-of-conversion, one bit per channel
//    x       in   N_CH*W   samples, channel i on bits [i*W +: W]
//    mode    in   2        00 average, 01 max, 10 min, 11 average
//    out     out  1        duration pulse
//    result  out  W        last reduced value
// ============================================================================
module multi_adc_pulse_gen #(
  parameter int N_CH  = 2,
  parameter int W     = 8,
  parameter int LOG2N = 1
) (
  input  logic              clock,
  input  logic              reset_,
  output logic [N_CH-1:0]   soc,
  input  logic [N_CH-1:0]   eoc,
  input  logic [N_CH*W-1:0] x,
  input  logic [1:0]        mode,
  output logic              out,
  output logic [W-1:0]      result
);

  typedef enum logic [1:0] {
    ST_SOC   = 2'd0,
    ST_EOC   = 2'd1,
    ST_CALC  = 2'd2,
    ST_PULSE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [W-1:0]        samples [N_CH];
  logic [W-1:0]        count;
  logic [W+LOG2N-1:0]  sum;
  logic [W-1:0]        max_val;
  logic [W-1:0]        min_val;
  logic [W-1:0]        reduced;
  logic                all_low;
  logic                all_high;

  assign all_low  = (eoc == '0);
  assign all_high = &eoc;

  // Sum is LOG2N bits wider than a sample, so it can never overflow and the
  // shifted average always fits back into W bits.
  always_comb begin
    sum     = '0;
    max_val = samples[0];
    min_val = samples[0];
    for (int i = 0; i < N_CH; i++) begin
      sum = sum + (W+LOG2N)'(samples[i]);
      if (samples[i] > max_val) max_val = samples[i];
      if (samples[i] < min_val) min_val = samples[i];
    end
  end

  always_comb begin
    case (mode)
      2'b01:   reduced = max_val;
      2'b10:   reduced = min_val;
      default: reduced = W'(sum >> LOG2N);
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) state <= ST_SOC;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_SOC:   if (all_low)  state_nx = ST_EOC;
      ST_EOC:   if (all_high) state_nx = ST_CALC;
      ST_CALC:  state_nx = (reduced != '0) ? ST_PULSE : ST_SOC;
      ST_PULSE: if (count == W'(1)) state_nx = ST_SOC;
      default:  state_nx = ST_SOC;
    endcase
  end

  // Registered outputs and datapath. A zero result skips PULSE entirely, so
  // count is never decremented from zero.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      soc    <= '0;
      out    <= 1'b0;
      result <= '0;
      count  <= '0;
      for (int i = 0; i < N_CH; i++) samples[i] <= '0;
    end else begin
      case (state)
        ST_SOC: begin
          soc <= '1;
          out <= 1'b0;
        end
        ST_EOC: begin
          soc <= '0;
          if (all_high) begin
            for (int i = 0; i < N_CH; i++) samples[i] <= x[i*W +: W];
          end
        end
        ST_CALC: begin
          result <= reduced;
          count  <= reduced;
          out    <= (reduced != '0);
        end
        ST_PULSE: begin
          count <= count - W'(1);
          if (count == W'(1)) out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
